disk_image_bridge: RTL and testbench

//  Bidirectional sector bridge between the SD-card buffer and disk images held in SRAM.

---
 rtl/disk_image_pkg.sv | 24 ++
 rtl/dib_arbiter.sv | 40 ++++
 rtl/disk_image_bridge.sv | 180 ++++++++++++++++++
 tb/tb_disk_image_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/disk_image_pkg.sv
// Shared types and helpers for the disk image sector bridge.
package disk_image_pkg;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [3:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    RD_STB,
    RD_NEXT,
    WR_ADDR,
    WR_CAP,
    WR_NEXT,
    DONE,
    RELEASE
  } dib_state_t;

  function automatic logic [31:0] lba_to_sector(input logic [31:0] lba,
                                                input logic [31:0] offset);
    return (lba >= offset) ? (lba - offset) : lba;
  endfunction

endpackage

// File: rtl/dib_arbiter.sv
// Fixed-priority request arbiter: lowest drive wins, read beats write within a drive.
module dib_arbiter
  import disk_image_pkg::*;
#(
  parameter int DRIVES = 2,
  parameter int DW     = 1
) (
  input  logic [DRIVES-1:0] rd_i,
  input  logic [DRIVES-1:0] wr_i,
  output logic              valid_o,
  output logic              is_wr_o,
  output logic [DW-1:0]     drive_o
);

  localparam int NREQ = 2 * DRIVES;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] onehot;

  always_comb begin
    req = '0;
    for (int d = 0; d < DRIVES; d++) begin
      req[2*d]   = rd_i[d];
      req[2*d+1] = wr_i[d];
    end
    // Isolate the lowest set request bit.
    onehot  = req & (~req + ONE);
    valid_o = |req;
    is_wr_o = 1'b0;
    drive_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (onehot[i]) begin
        is_wr_o = i[0];
        drive_o = DW'(i / 2);
      end
    end
  end

endmodule

// File: rtl/disk_image_bridge.sv
// Sector bridge between the SD buffer and per-drive disk images in SRAM.
// States: IDLE wait/grant | RD_WAIT sram latency | RD_CAP capture | RD_STB buffer write | RD_NEXT advance
//         WR_ADDR present addr | WR_CAP capture+we | WR_NEXT advance | DONE drop ack | RELEASE wait req low
module disk_image_bridge
  import disk_image_pkg::*;
#(
  parameter int          DRIVES     = 2,
  parameter int          SECT_BITS  = 10,
  parameter logic [31:0] LBA_OFFSET = 32'd256,
  parameter int          SRAM_LAT   = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'hE5,
  localparam int         DW         = (DRIVES > 1) ? $clog2(DRIVES) : 1,
  localparam int         AW         = DW + SECT_BITS + 9
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       sd_lba,
  input  logic [DRIVES-1:0] sd_rd,
  input  logic [DRIVES-1:0] sd_wr,
  output logic              sd_ack,
  output logic [DW-1:0]     sd_drive_o,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  output logic [AW-1:0]     sram_addr_o,
  input  logic [7:0]        sram_data_i,
  output logic [7:0]        sram_data_o,
  output logic              sram_we_o,
  output logic              busy_o
);

  localparam logic [1:0] WAIT_INIT = 2'(SRAM_LAT - 1);
  localparam logic [8:0] LAST_BYTE = 9'(SECTOR_BYTES - 1);

  dib_state_t           state_q, state_d;
  logic [DW-1:0]        drv_q, drv_d;
  logic                 wr_q, wr_d;
  logic [SECT_BITS-1:0] sec_q, sec_d;
  logic                 oor_q, oor_d;
  logic [8:0]           byte_q, byte_d;
  logic [1:0]           wait_q, wait_d;
  logic                 ack_q, ack_d;
  logic [7:0]           dout_q, dout_d;
  logic [7:0]           sdata_q, sdata_d;
  logic                 we_q, we_d;

  logic                 gnt_valid;
  logic                 gnt_wr;
  logic [DW-1:0]        gnt_drv;
  logic [31:0]          lba_s;
  logic                 lba_oor;
  logic                 req_held;

  dib_arbiter #(.DRIVES(DRIVES), .DW(DW)) u_arb (
    .rd_i    (sd_rd),
    .wr_i    (sd_wr),
    .valid_o (gnt_valid),
    .is_wr_o (gnt_wr),
    .drive_o (gnt_drv)
  );

  assign lba_s   = lba_to_sector(sd_lba, LBA_OFFSET);
  assign lba_oor = (lba_s >> SECT_BITS) != 32'd0;

  always_comb begin
    req_held = 1'b0;
    for (int d = 0; d < DRIVES; d++) begin
      if (DW'(d) == drv_q) req_held = wr_q ? sd_wr[d] : sd_rd[d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      drv_q   <= '0;
      wr_q    <= 1'b0;
      sec_q   <= '0;
      oor_q   <= 1'b0;
      byte_q  <= '0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      dout_q  <= '0;
      sdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drv_q   <= drv_d;
      wr_q    <= wr_d;
      sec_q   <= sec_d;
      oor_q   <= oor_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      sdata_q <= sdata_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drv_d   = drv_q;
    wr_d    = wr_q;
    sec_d   = sec_q;
    oor_d   = oor_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    ack_d   = ack_q;
    dout_d  = dout_q;
    sdata_d = sdata_q;
    we_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          drv_d  = gnt_drv;
          wr_d   = gnt_wr;
          sec_d  = lba_s[SECT_BITS-1:0];
          oor_d  = lba_oor;
          byte_d = '0;
          ack_d  = 1'b1;
          if (gnt_wr) begin
            state_d = WR_ADDR;
          end else begin
            wait_d  = WAIT_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) state_d = RD_CAP;
        else                wait_d  = wait_q - 2'd1;
      end
      RD_CAP: begin
        dout_d  = oor_q ? FILL_BYTE : sram_data_i;
        state_d = RD_STB;
      end
      RD_STB: state_d = RD_NEXT;
      RD_NEXT: begin
        byte_d = byte_q + 9'd1;
        if (byte_q == LAST_BYTE) begin
          state_d = DONE;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = RD_WAIT;
        end
      end
      WR_ADDR: state_d = WR_CAP;
      WR_CAP: begin
        // Strobe is registered so it lines up with the captured data.
        sdata_d = sd_buff_din;
        we_d    = ~oor_q;
        state_d = WR_NEXT;
      end
      WR_NEXT: begin
        byte_d  = byte_q + 9'd1;
        state_d = (byte_q == LAST_BYTE) ? DONE : WR_ADDR;
      end
      DONE: begin
        ack_d   = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req_held) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd_ack       = ack_q;
  assign sd_drive_o   = drv_q;
  assign sd_buff_addr = byte_q;
  assign sd_buff_dout = dout_q;
  assign sd_buff_wr   = (state_q == RD_STB);
  assign sram_addr_o  = {drv_q, sec_q, byte_q};
  assign sram_data_o  = sdata_q;
  assign sram_we_o    = we_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_disk_image_bridge.sv
// Directed bench for disk_image_bridge: two instances (SRAM latency 1 and 3) with a shared buffer model.
module tb_disk_image_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [31:0] sd_lba;
  logic [1:0]  rd_v, wr_v;
  logic        sel;
  logic [7:0]  buf_din;

  logic        ack0, drv0, bwr0, we0, busy0;
  logic [8:0]  baddr0;
  logic [7:0]  bdout0, sdo0, sdi0;
  logic [19:0] saddr0;
  logic        ack1, drv1, bwr1, we1, busy1;
  logic [8:0]  baddr1;
  logic [7:0]  bdout1, sdo1, sdi1, p1_a, p1_b;
  logic [19:0] saddr1;

  logic [1:0]  rd0_in, wr0_in, rd1_in, wr1_in;
  assign rd0_in = sel ? 2'b00 : rd_v;
  assign wr0_in = sel ? 2'b00 : wr_v;
  assign rd1_in = sel ? rd_v : 2'b00;
  assign wr1_in = sel ? wr_v : 2'b00;

  logic        m_ack, m_drv, m_bwr, m_we, m_busy;
  logic [8:0]  m_baddr;
  logic [7:0]  m_bdout, m_sdo;
  logic [19:0] m_saddr;
  assign m_ack   = sel ? ack1   : ack0;
  assign m_drv   = sel ? drv1   : drv0;
  assign m_bwr   = sel ? bwr1   : bwr0;
  assign m_we    = sel ? we1    : we0;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_baddr = sel ? baddr1 : baddr0;
  assign m_bdout = sel ? bdout1 : bdout0;
  assign m_sdo   = sel ? sdo1   : sdo0;
  assign m_saddr = sel ? saddr1 : saddr0;

  // SD buffer holds A5^index, read with one cycle of latency.
  always @(posedge clk) buf_din <= 8'hA5 ^ m_baddr[7:0];
  // SRAM images hold addr[7:0]; pipelines model 1 and 3 cycles of latency.
  always @(posedge clk) sdi0 <= saddr0[7:0];
  always @(posedge clk) begin
    p1_a <= saddr1[7:0];
    p1_b <= p1_a;
    sdi1 <= p1_b;
  end

  disk_image_bridge #(.SRAM_LAT(1)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .sd_lba(sd_lba), .sd_rd(rd0_in), .sd_wr(wr0_in),
    .sd_ack(ack0), .sd_drive_o(drv0), .sd_buff_addr(baddr0), .sd_buff_dout(bdout0),
    .sd_buff_din(buf_din), .sd_buff_wr(bwr0), .sram_addr_o(saddr0), .sram_data_i(sdi0),
    .sram_data_o(sdo0), .sram_we_o(we0), .busy_o(busy0)
  );

  disk_image_bridge #(.SRAM_LAT(3)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .sd_lba(sd_lba), .sd_rd(rd1_in), .sd_wr(wr1_in),
    .sd_ack(ack1), .sd_drive_o(drv1), .sd_buff_addr(baddr1), .sd_buff_dout(bdout1),
    .sd_buff_din(buf_din), .sd_buff_wr(bwr1), .sram_addr_o(saddr1), .sram_data_i(sdi1),
    .sram_data_o(sdo1), .sram_we_o(we1), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Serves one already-requested transfer, then drops its request bit in RELEASE.
  task automatic serve(input string tag, input bit is_wr, input int drv, input int sec,
                       input bit oor, input int cpb);
    int acks, strobes, other, bad, mis, rel_bad, n;
    bit seen;
    seen = 0;
    for (n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (m_ack) seen = 1;
    end
    chk({tag, ".ack"}, 64'(seen), 64'd1);
    chk({tag, ".drive"}, 64'(m_drv), 64'(drv[0]));
    acks = 0; strobes = 0; other = 0; bad = 0; mis = 0; n = 0;
    while (m_ack && n < 5000) begin
      acks++;
      n++;
      if (m_baddr !== m_saddr[8:0]) mis++;
      if (is_wr) begin
        if (m_we) begin
          if (m_saddr !== {drv[0], sec[9:0], strobes[8:0]} || m_sdo !== (8'hA5 ^ strobes[7:0])) bad++;
          strobes++;
        end
        if (m_bwr) other++;
      end else begin
        if (m_bwr) begin
          if (m_saddr !== {drv[0], sec[9:0], strobes[8:0]} ||
              m_bdout !== (oor ? 8'hE5 : strobes[7:0])) bad++;
          strobes++;
        end
        if (m_we) other++;
      end
      @(negedge clk);
    end
    // 512 bytes of cpb cycles each, plus the DONE cycle.
    chk({tag, ".ack_cycles"}, 64'(acks), 64'(512 * cpb + 1));
    chk({tag, ".strobes"}, 64'(strobes), (is_wr && oor) ? 64'd0 : 64'd512);
    chk({tag, ".data_bad"}, 64'(bad), 64'd0);
    chk({tag, ".other_strobe"}, 64'(other), 64'd0);
    chk({tag, ".addr_mismatch"}, 64'(mis), 64'd0);
    rel_bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_ack !== 1'b0 || m_busy !== 1'b1) rel_bad++;
      if (i < 2) @(negedge clk);
    end
    chk({tag, ".release_hold"}, 64'(rel_bad), 64'd0);
    if (is_wr) wr_v[drv] = 1'b0;
    else       rd_v[drv] = 1'b0;
    @(negedge clk);
    chk({tag, ".idle"}, 64'(m_busy), 64'd0);
  endtask

  initial begin
    int wes, n;
    reset_i = 1'b1;
    sd_lba  = 32'd0;
    rd_v    = 2'b00;
    wr_v    = 2'b00;
    sel     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset0", {ack0, drv0, baddr0, bdout0, bwr0, saddr0, sdo0, we0, busy0}, 64'd0);
    chk("reset1", {ack1, drv1, baddr1, bdout1, bwr1, saddr1, sdo1, we1, busy1}, 64'd0);
    reset_i = 1'b0;
    @(negedge clk);

    // Read drive 0, lba 300 -> sector 44.
    sd_lba = 32'd300; rd_v[0] = 1'b1;
    serve("t1_rd", 0, 0, 44, 0, 4);

    // Write drive 1, lba 5 (below offset) -> sector 5.
    sd_lba = 32'd5; wr_v[1] = 1'b1;
    serve("t2_wr", 1, 1, 5, 0, 3);

    // Simultaneous rd0, wr0, rd1: served in priority order, one per release.
    sd_lba = 32'd300; rd_v = 2'b11; wr_v[0] = 1'b1;
    serve("t3_rd0", 0, 0, 44, 0, 4);
    serve("t3_wr0", 1, 0, 44, 0, 3);
    serve("t3_rd1", 0, 1, 44, 0, 4);

    // Out-of-range sector 1024: fill bytes on read, no SRAM writes.
    sd_lba = 32'd1280; rd_v[0] = 1'b1;
    serve("t4_oor_rd", 0, 0, 0, 1, 4);
    wr_v[0] = 1'b1;
    serve("t4_oor_wr", 1, 0, 0, 1, 3);

    // SRAM latency 3 on the second instance; lba 1279 is the last in-range sector.
    sel = 1'b1;
    @(negedge clk);
    sd_lba = 32'd1279; rd_v[0] = 1'b1;
    serve("t5_lat3", 0, 0, 1023, 0, 6);
    sel = 1'b0;
    @(negedge clk);

    // Reset while the write is presenting byte 100.
    sd_lba = 32'd5; wr_v[1] = 1'b1;
    wes = 0; n = 0;
    while (!(ack0 && baddr0 == 9'd100) && n < 1000) begin
      @(negedge clk);
      if (we0) wes++;
      n++;
    end
    chk("t6_reached", 64'(baddr0), 64'd100);
    reset_i = 1'b1; wr_v = 2'b00;
    @(negedge clk);
    chk("t6_reset_outs", {ack0, drv0, baddr0, bdout0, bwr0, saddr0, sdo0, we0, busy0}, 64'd0);
    reset_i = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (we0) wes++;
    end
    chk("t6_we_count", 64'(wes), 64'd100);
    sd_lba = 32'd7; wr_v[0] = 1'b1;
    serve("t6_fresh", 1, 0, 7, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
